// File: rtl/mbist_march_ctrl.sv
// March C- sequencer for a single-port SRAM; streams each read mismatch to the repair allocator.
// Optional build macro MBIST_STOP_ON_FAIL_EN ends the test at the first mismatch.
module mbist_march_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic              fail_valid,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [CNT_W-1:0]  fail_count
);

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_phase;
   logic              r_fail;
   logic [CNT_W-1:0]  r_fail_count;

   logic              w_active;
   logic              w_rw_elem;
   logic              w_cmp;
   logic              w_desc;
   logic              w_last;
   logic              w_step;
   logic              w_mismatch;
   logic              w_we_raw;
   logic [DATA_W-1:0] w_exp;
   state_t            w_next_elem;

   assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_rw_elem  = w_active && (r_state != S_M0);
   assign w_cmp      = w_rw_elem && r_phase;
   assign w_desc     = (r_state == S_M3) || (r_state == S_M4);
   assign w_last     = w_desc ? (r_addr == '0) : (r_addr == '1);
   assign w_step     = (r_state == S_M0) || w_cmp;
   assign w_exp      = ((r_state == S_M2) || (r_state == S_M4)) ? '1 : '0;
   assign w_mismatch = w_cmp && (mem_rdata != w_exp);
   assign w_we_raw   = (r_state == S_M0) || (w_cmp && (r_state != S_M5));
   assign w_next_elem = state_t'(r_state + 4'd1);

`ifdef MBIST_STOP_ON_FAIL_EN
   // The write that would follow a failing compare is dropped: the test ends here.
   assign mem_we = w_we_raw && !w_mismatch;
`else
   assign mem_we = w_we_raw;
`endif

   assign mem_re     = w_rw_elem && !r_phase;
   assign mem_wdata  = (mem_we && ((r_state == S_M1) || (r_state == S_M3))) ? '1 : '0;
   assign mem_addr   = r_addr;
   assign busy       = w_active;
   assign done       = (r_state == S_DONE);
   assign fail       = r_fail;
   assign fail_count = r_fail_count;
   assign fail_valid = w_mismatch;
   assign fail_addr  = w_mismatch ? r_addr : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_phase      <= 1'b0;
         r_fail       <= 1'b0;
         r_fail_count <= '0;
      end else begin
         if (w_mismatch) begin
            r_fail <= 1'b1;
            if (r_fail_count != '1) r_fail_count <= r_fail_count + 1'b1;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state      <= S_M0;
                  r_addr       <= '0;
                  r_phase      <= 1'b0;
                  r_fail       <= 1'b0;
                  r_fail_count <= '0;
               end
            end
            default: begin
               if (w_step) begin
                  r_phase <= 1'b0;
`ifdef MBIST_STOP_ON_FAIL_EN
                  if (w_mismatch) begin
                     r_state <= S_DONE;
                  end else
`endif
                  if (w_last) begin
                     // Next element starts at its own first address: top for descending passes.
                     r_state <= w_next_elem;
                     r_addr  <= ((w_next_elem == S_M3) || (w_next_elem == S_M4)) ? '1 : '0;
                  end else begin
                     r_addr <= w_desc ? r_addr - 1'b1 : r_addr + 1'b1;
                  end
               end else begin
                  r_phase <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl: faulty SRAM harness plus an algorithmic March C- model.
module tb_mbist_march_ctrl;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;
   localparam int D      = 1 << ADDR_W;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we, mem_re;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              busy, done, fail, fail_valid;
   logic [ADDR_W-1:0] fail_addr;
   logic [CNT_W-1:0]  fail_count;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mem [D];
   logic [DATA_W-1:0] sa0 [D];
   logic [DATA_W-1:0] sa1 [D];
   int got_q[$];
   int exp_q[$];
   int busy_cnt = 0;
   int rule_viol = 0;

   always #5 clk = ~clk;

   mbist_march_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
      .fail_valid(fail_valid), .fail_addr(fail_addr), .fail_count(fail_count)
   );

   // SRAM with stuck-at bits applied on read
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= (mem[mem_addr] & ~sa0[mem_addr]) | sa1[mem_addr];
   end

   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (fail_valid) got_q.push_back(int'(fail_addr));
      if ((mem_we && mem_re) || (!mem_we && mem_wdata != '0)) rule_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      for (int a = 0; a < D; a++) begin
         sa0[a] = '0;
         sa1[a] = '0;
      end
   endtask

   // March C- walked element by element; returns expected busy cycles and fills exp_q.
   task automatic model(output int cycles);
      logic [DATA_W-1:0] m [D];
      logic [DATA_W-1:0] rd, ev;
      bit stop;
      int a;
      exp_q.delete();
      cycles = 0;
      stop = 0;
      for (int k = 0; k < D; k++) begin
         m[k] = '0;
         cycles++;
      end
      for (int e = 1; e <= 5; e++) begin
         for (int k = 0; k < D; k++) begin
            if (stop) continue;
            a = (e == 3 || e == 4) ? D - 1 - k : k;
            cycles += 2;
            rd = (m[a] & ~sa0[a]) | sa1[a];
            ev = (e == 2 || e == 4) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            if (rd != ev) begin
               exp_q.push_back(a);
`ifdef MBIST_STOP_ON_FAIL_EN
               stop = 1;
               continue;
`endif
            end
            if (e <= 4) m[a] = (e == 1 || e == 3) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".ctl"}, {busy, done, fail, fail_valid, mem_we, mem_re}, 0);
      chk({tag, ".addr"}, mem_addr, 0);
      chk({tag, ".wdata"}, mem_wdata, 0);
      chk({tag, ".fcnt"}, fail_count, 0);
      chk({tag, ".faddr"}, fail_addr, 0);
   endtask

   task automatic run(input string tag, input int restart_at);
      int exp_cycles, cyc, n, cnt;
      model(exp_cycles);
      n = exp_q.size();
      cnt = (n > CMAX) ? CMAX : n;
      @(negedge clk);
      got_q.delete();
      busy_cnt = 0;
      rule_viol = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk({tag, ".first"}, {busy, done, fail, mem_we, mem_re}, 5'b10010);
      chk({tag, ".first_addr"}, mem_addr, 0);
      chk({tag, ".cleared_cnt"}, fail_count, 0);
      cyc = 0;
      while (!done && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
      end
      start = 1'b0;
      #1;
      chk({tag, ".done"}, done, 1);
      chk({tag, ".busy_cycles"}, busy_cnt, exp_cycles);
      chk({tag, ".n_pulses"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++)
         chk({tag, ".pulse_addr"}, got_q[i], exp_q[i]);
      chk({tag, ".fail"}, fail, (n > 0));
      chk({tag, ".fail_count"}, fail_count, cnt);
      chk({tag, ".rw_rules"}, rule_viol, 0);
      repeat (3) @(negedge clk);
      chk({tag, ".hold"}, {busy, done, fail, fail_count}, {2'b01, (n > 0), cnt[CNT_W-1:0]});
      $display("run %s: pulses=%0d busy=%0d count=%0d", tag, got_q.size(), busy_cnt, fail_count);
   endtask

   initial begin
      int a, f;
      for (int k = 0; k < D; k++) mem[k] = DATA_W'($urandom);
      clear_faults();
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run("clean", 0);

      sa0[5] = 8'h08;
      run("sa0_a5_b3", 0);

      clear_faults();
      sa1[12] = 8'h01;
      run("sa1_a12_b0", 40);

      // many stuck cells push the counter past saturation
      clear_faults();
      for (int k = 0; k < 7; k++) sa1[2 * k + 1][$urandom_range(DATA_W - 1)] = 1'b1;
      run("saturate", 0);

      // asynchronous reset mid-run, with a fault already counted
      clear_faults();
      sa1[12] = 8'h01;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (59) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      clear_faults();
      run("after_reset", 0);

      for (int r = 0; r < 4; r++) begin
         clear_faults();
         f = $urandom_range(3);
         for (int k = 0; k < f; k++) begin
            a = $urandom_range(D - 1);
            if ($urandom_range(1) == 1) sa1[a][$urandom_range(DATA_W - 1)] = 1'b1;
            else sa0[a][$urandom_range(DATA_W - 1)] = 1'b1;
         end
         run($sformatf("rand%0d", r), (r == 1) ? 100 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
